// File: rtl/fft32_input_framer.sv
// Input framer for the 32-point FFT: packs a valid/ready sample stream into
// 32-sample frames in a two-bank ping-pong buffer and presents each as a flat bus.
module fft32_input_framer #(
  parameter int DATA_WIDTH  = 32,
  parameter int LOG2_NFFT   = 5,
  parameter int NFFT_POINTS = 2**LOG2_NFFT
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_WIDTH-1:0]             in_r,
  input  logic [DATA_WIDTH-1:0]             in_i,
  input  logic                              in_valid,
  input  logic                              in_last,
  output logic                              in_ready,
  output logic [NFFT_POINTS*DATA_WIDTH-1:0] frame_r,
  output logic [NFFT_POINTS*DATA_WIDTH-1:0] frame_i,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              err_frame,
  output logic [15:0]                       frame_cnt
);

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_t;

  bank_state_t            state_q [2];
  bank_state_t            state_d [2];
  logic [LOG2_NFFT-1:0]   wr_idx;
  logic                   wr_sel;
  logic                   rd_sel;
  logic [DATA_WIDTH-1:0]  mem_r [2][NFFT_POINTS];
  logic [DATA_WIDTH-1:0]  mem_i [2][NFFT_POINTS];

  logic accept;
  logic rd_fire;
  logic last_slot;

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high; valid never waits on ready, and data is held while valid & ~ready.
  assign in_ready  = (state_q[wr_sel] != BANK_FULL);
  assign out_valid = (state_q[rd_sel] == BANK_FULL);
  assign accept    = in_valid & in_ready;
  assign rd_fire   = out_valid & out_ready;
  assign last_slot = (wr_idx == LOG2_NFFT'(NFFT_POINTS-1));

  // Write and read always target different banks when both fire, because the
  // read bank is FULL and a FULL write bank blocks acceptance.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      state_d[b] = state_q[b];
      if (accept && (wr_sel == 1'(b))) begin
        if (last_slot)    state_d[b] = BANK_FULL;
        else if (in_last) state_d[b] = BANK_EMPTY;
        else              state_d[b] = BANK_FILLING;
      end
      if (rd_fire && (rd_sel == 1'(b))) state_d[b] = BANK_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q[0] <= BANK_EMPTY;
      state_q[1] <= BANK_EMPTY;
      wr_idx     <= '0;
      wr_sel     <= 1'b0;
      rd_sel     <= 1'b0;
      err_frame  <= 1'b0;
      frame_cnt  <= 16'd0;
    end else begin
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      err_frame  <= accept & (in_last ^ last_slot);
      if (accept) begin
        if (last_slot) begin
          wr_idx <= '0;
          wr_sel <= ~wr_sel;
        end else if (in_last) begin
          // early in_last abandons the partial frame; the bank is refilled from slot 0
          wr_idx <= '0;
        end else begin
          wr_idx <= wr_idx + 1'b1;
        end
      end
      if (rd_fire) begin
        rd_sel    <= ~rd_sel;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  // Sample storage is not reset; validity is tracked only by the bank states.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_r[wr_sel][wr_idx] <= in_r;
      mem_i[wr_sel][wr_idx] <= in_i;
    end
  end

  always_comb begin
    frame_r = '0;
    frame_i = '0;
    for (int k = 0; k < NFFT_POINTS; k++) begin
      frame_r[k*DATA_WIDTH +: DATA_WIDTH] = mem_r[rd_sel][k];
      frame_i[k*DATA_WIDTH +: DATA_WIDTH] = mem_i[rd_sel][k];
    end
  end

endmodule

// File: tb/tb_fft32_input_framer.sv
// Bench for fft32_input_framer: table-driven stream scenarios, backpressure and
// reset sequences, and a long random run, all checked against a frame scoreboard.
module tb_fft32_input_framer;

  localparam int DW = 32;
  localparam int N  = 32;
  localparam int FW = N * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_r = '0;
  logic [DW-1:0] in_i = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic [FW-1:0] frame_r;
  logic [FW-1:0] frame_i;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          err_frame;
  logic [15:0]   frame_cnt;

  always #5 clk = ~clk;

  fft32_input_framer #(.DATA_WIDTH(DW), .LOG2_NFFT(5), .NFFT_POINTS(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_r      (in_r),
    .in_i      (in_i),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .frame_r   (frame_r),
    .frame_i   (frame_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_frame (err_frame),
    .frame_cnt (frame_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [2*DW-1:0] exp_q[$];
  logic [2*DW-1:0] pend_q[$];
  int              exp_cnt = 0;
  bit              err_pend = 1'b0;
  int              obs_err = 0;
  int              obs_frames = 0;
  logic [DW-1:0]   last_r0 = '0;
  bit              hold_v = 1'b0;
  logic [FW-1:0]   hold_r, hold_i;
  logic [FW-1:0]   er, ei;
  logic [2*DW-1:0] e;
  int              bad_k;
  bit              rnd_rdy = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic summary_and_stop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  // Monitor at the falling edge: compare against the model state left by the
  // previous edge, then update the model with what the next rising edge will do.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      pend_q.delete();
      exp_cnt  = 0;
      err_pend = 1'b0;
      hold_v   = 1'b0;
    end else begin
      chk("out_valid", out_valid, exp_q.size() >= N);
      chk("in_ready", in_ready, exp_q.size() < 2*N);
      chk("err_frame", err_frame, err_pend);
      chk("frame_cnt", frame_cnt, exp_cnt[15:0]);
      if (err_frame) obs_err++;
      if (hold_v) chk("held_frame", (frame_r === hold_r) && (frame_i === hold_i), 1);
      hold_v = out_valid & ~out_ready;
      hold_r = frame_r;
      hold_i = frame_i;
      if (out_valid && out_ready) begin
        if (exp_q.size() < N) begin
          chk("frame_avail", exp_q.size(), N);
        end else begin
          for (int k = 0; k < N; k++) begin
            e = exp_q.pop_front();
            er[k*DW +: DW] = e[2*DW-1:DW];
            ei[k*DW +: DW] = e[DW-1:0];
          end
          bad_k = -1;
          for (int k = 0; k < N; k++)
            if (bad_k < 0 && (frame_r[k*DW +: DW] !== er[k*DW +: DW] ||
                              frame_i[k*DW +: DW] !== ei[k*DW +: DW]))
              bad_k = k;
          n_cmp++;
          if (bad_k >= 0) begin
            n_bad++;
            $display("FAIL frame_data: sample %0d got r=%0h i=%0h expected r=%0h i=%0h",
                     bad_k, frame_r[bad_k*DW +: DW], frame_i[bad_k*DW +: DW],
                     er[bad_k*DW +: DW], ei[bad_k*DW +: DW]);
          end
        end
        exp_cnt++;
        obs_frames++;
        last_r0 = frame_r[DW-1:0];
      end
      err_pend = 1'b0;
      if (in_valid && in_ready) begin
        pend_q.push_back({in_r, in_i});
        if (pend_q.size() == N) begin
          if (!in_last) err_pend = 1'b1;
          foreach (pend_q[k]) exp_q.push_back(pend_q[k]);
          pend_q.delete();
        end else if (in_last) begin
          err_pend = 1'b1;
          pend_q.delete();
        end
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int v, input bit last);
    in_r = DW'(v);
    in_i = DW'(-v);
    in_last = last;
    in_valid = 1'b1;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (in_ready) break;
      if (t > 3000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL send_timeout: in_ready stuck low for value %0d", v);
        summary_and_stop();
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  typedef struct {
    int first;
    int n;
    int last_at;
    bit rdy;
    int exp_err;
    int exp_frames;
    int exp_r0;
  } vec_t;

  vec_t vecs[5];
  int   e0, f0;

  initial begin
    vecs[0] = '{first: 0,   n: 32, last_at: 31, rdy: 1'b1, exp_err: 0, exp_frames: 1, exp_r0: 0};
    vecs[1] = '{first: 300, n: 10, last_at: 9,  rdy: 1'b1, exp_err: 1, exp_frames: 0, exp_r0: 0};
    vecs[2] = '{first: 100, n: 32, last_at: 31, rdy: 1'b1, exp_err: 0, exp_frames: 1, exp_r0: 100};
    vecs[3] = '{first: 200, n: 32, last_at: -1, rdy: 1'b1, exp_err: 1, exp_frames: 1, exp_r0: 200};
    vecs[4] = '{first: 500, n: 64, last_at: 31, rdy: 1'b1, exp_err: 0, exp_frames: 2, exp_r0: 532};

    tick(2);
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_err_frame", err_frame, 0);
    chk("rst_frame_cnt", frame_cnt, 0);

    for (int r = 0; r < 5; r++) begin
      out_ready = vecs[r].rdy;
      e0 = obs_err;
      f0 = obs_frames;
      for (int j = 0; j < vecs[r].n; j++)
        send(vecs[r].first + j, (j % 32) == vecs[r].last_at);
      tick(4);
      chk("vec_err_count", obs_err - e0, vecs[r].exp_err);
      chk("vec_frame_count", obs_frames - f0, vecs[r].exp_frames);
      if (vecs[r].exp_frames > 0) chk("vec_first_r", last_r0, vecs[r].exp_r0);
    end
    chk("table_frame_cnt", frame_cnt, 5);

    // three back-to-back frames against a stalled consumer
    out_ready = 1'b0;
    f0 = obs_frames;
    fork
      for (int j = 0; j < 96; j++) send(1000 + j, (j % 32) == 31);
      begin
        tick(100);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_frame0_r", frame_r[DW-1:0], 1000);
        out_ready = 1'b1;
      end
    join
    tick(6);
    chk("bp_frames", obs_frames - f0, 3);
    chk("bp_last_r0", last_r0, 1064);

    // reset with one full frame pending and a partial frame in progress
    out_ready = 1'b0;
    for (int j = 0; j < 32; j++) send(2000 + j, j == 31);
    for (int j = 0; j < 20; j++) send(2100 + j, 1'b0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_frame_cnt", frame_cnt, 0);
    out_ready = 1'b1;
    f0 = obs_frames;
    for (int j = 0; j < 32; j++) send(3000 + j, j == 31);
    tick(4);
    chk("post_rst_frames", obs_frames - f0, 1);
    chk("post_rst_r0", last_r0, 3000);
    chk("post_rst_frame_cnt", frame_cnt, 1);

    // long random run with input gaps and output backpressure
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    f0 = obs_frames;
    rnd_rdy = 1'b1;
    for (int f = 0; f < 1000; f++)
      for (int j = 0; j < 32; j++) begin
        if ($urandom_range(0, 9) == 0) tick(1);
        send(5000 + f*32 + j, j == 31);
      end
    rnd_rdy = 1'b0;
    tick(1);
    out_ready = 1'b1;
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) tick(1);
    tick(2);
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_frames", obs_frames - f0, 1000);
    chk("rand_frame_cnt", frame_cnt, 1000);

    summary_and_stop();
  end

endmodule
